// File: rtl/squ_pkg.sv
// Shared opcode encodings and decoded-operation type for stack_queue_unit.
// FIFO_WRITE and LIFO_WRITE both decode to OP_K_PUSH.
package squ_pkg;

   localparam logic [3:0] OP_NOP          = 4'b0000;
   localparam logic [3:0] OP_CLEAR        = 4'b0001;
   localparam logic [3:0] OP_BUFFER       = 4'b0100;
   localparam logic [3:0] OP_FIFO_WRITE   = 4'b1001;
   localparam logic [3:0] OP_FIFO_READ    = 4'b1010;
   localparam logic [3:0] OP_FIFO_RW      = 4'b1011;
   localparam logic [3:0] OP_LIFO_WRITE   = 4'b1101;
   localparam logic [3:0] OP_LIFO_READ    = 4'b1110;
   localparam logic [3:0] OP_LIFO_REPLACE = 4'b1111;

   typedef enum logic [3:0] {
      OP_K_NOP,
      OP_K_CLEAR,
      OP_K_BUFFER,
      OP_K_PUSH,
      OP_K_POP_HEAD,
      OP_K_POP_TAIL,
      OP_K_FIFO_RW,
      OP_K_REPLACE,
      OP_K_ILLEGAL
   } op_e;

   function automatic op_e decode_op(input logic [3:0] code);
      op_e k;
      case (code)
         OP_NOP:          k = OP_K_NOP;
         OP_CLEAR:        k = OP_K_CLEAR;
         OP_BUFFER:       k = OP_K_BUFFER;
         OP_FIFO_WRITE,
         OP_LIFO_WRITE:   k = OP_K_PUSH;
         OP_FIFO_READ:    k = OP_K_POP_HEAD;
         OP_LIFO_READ:    k = OP_K_POP_TAIL;
         OP_FIFO_RW:      k = OP_K_FIFO_RW;
         OP_LIFO_REPLACE: k = OP_K_REPLACE;
         default:         k = OP_K_ILLEGAL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/squ_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous
// read port, contents not reset.
module squ_mem #(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned DEPTH  = 8,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_queue_unit.sv
// Double-ended queue executing interleaved FIFO/LIFO commands over one shared
// storage array, with registered read data and one-cycle error pulses.
module stack_queue_unit
   import squ_pkg::*;
#(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned DEPTH  = 8,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              err_ovf,
   output logic              err_udf,
   output logic              err_op
);

   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

   op_e               op;
   logic [ADDR_W-1:0] head_q, tail_q, tail_m1;
   logic [ADDR_W-1:0] head_d, tail_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] dout_d, rdata;
   logic              ov_d, eovf_d, eudf_d, eop_d;
   logic              is_empty, is_full;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr, mem_raddr;

   assign op       = decode_op(opcode);
   assign tail_m1  = tail_q - PTR_ONE;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   squ_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (data_in),
      .raddr (mem_raddr),
      .rdata (rdata)
   );

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      dout_d    = data_out;
      ov_d      = 1'b0;
      eovf_d    = 1'b0;
      eudf_d    = 1'b0;
      eop_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = tail_q;
      mem_raddr = head_q;
      case (op)
         OP_K_CLEAR: begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end
         OP_K_BUFFER: begin
            dout_d = data_in;
            ov_d   = 1'b1;
         end
         OP_K_PUSH: begin
            if (is_full) begin
               eovf_d = 1'b1;
            end else begin
               mem_we  = 1'b1;
               tail_d  = tail_q + PTR_ONE;
               count_d = count_q + CNT_ONE;
            end
         end
         OP_K_POP_HEAD: begin
            if (is_empty) begin
               eudf_d = 1'b1;
            end else begin
               dout_d  = rdata;
               ov_d    = 1'b1;
               head_d  = head_q + PTR_ONE;
               count_d = count_q - CNT_ONE;
            end
         end
         OP_K_POP_TAIL: begin
            mem_raddr = tail_m1;
            if (is_empty) begin
               eudf_d = 1'b1;
            end else begin
               dout_d  = rdata;
               ov_d    = 1'b1;
               tail_d  = tail_m1;
               count_d = count_q - CNT_ONE;
            end
         end
         // When full, head == tail: the async read sees the old word before
         // the same-address write lands at the edge.
         OP_K_FIFO_RW: begin
            mem_we = 1'b1;
            tail_d = tail_q + PTR_ONE;
            if (is_empty) begin
               eudf_d  = 1'b1;
               count_d = count_q + CNT_ONE;
            end else begin
               dout_d = rdata;
               ov_d   = 1'b1;
               head_d = head_q + PTR_ONE;
            end
         end
         OP_K_REPLACE: begin
            mem_raddr = tail_m1;
            mem_we    = 1'b1;
            if (is_empty) begin
               eudf_d  = 1'b1;
               tail_d  = tail_q + PTR_ONE;
               count_d = count_q + CNT_ONE;
            end else begin
               mem_waddr = tail_m1;
               dout_d    = rdata;
               ov_d      = 1'b1;
            end
         end
         OP_K_ILLEGAL: eop_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         err_ovf   <= 1'b0;
         err_udf   <= 1'b0;
         err_op    <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         data_out  <= dout_d;
         out_valid <= ov_d;
         err_ovf   <= eovf_d;
         err_udf   <= eudf_d;
         err_op    <= eop_d;
      end
   end

   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;

endmodule

// File: doc/stack_queue_unit.md
# stack_queue_unit

Parametrised successor to the single-mode FIFO/LIFO executor: one shared storage array is managed as a double-ended queue so FIFO and LIFO commands can be interleaved freely without pointer re-mapping on mode switch. It adds per-cycle combined push/pop, occupancy count, wrap-around pointers, registered read data with a valid strobe, and overflow/underflow/illegal-op flags. It sits between the opcode decoder and the datapath consumer, in place of the previous executor.

## Interface
- DATA_W, 8, data word width
- DEPTH, 8, number of entries; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), derived; not to be overridden
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- opcode  in  4  command, sampled every cycle
- data_in  in  DATA_W  write/buffer operand
- data_out  out  DATA_W  registered read/buffer result
- out_valid  out  1  one-cycle strobe, data_out updated this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  ADDR_W+1  current occupancy
- err_ovf  out  1  one-cycle pulse: push refused
- err_udf  out  1  one-cycle pulse: pop refused
- err_op  out  1  one-cycle pulse: undefined opcode

## Operation
- Contents are an ordered sequence head (oldest) … tail-1 (newest); head, tail are ADDR_W-bit pointers wrapping mod DEPTH; count disambiguates full/empty.
- Opcodes: 0000 NOP; 0001 CLEAR (head=tail=count=0, data_out retained); 0100 BUFFER (data_out<=data_in, out_valid=1, no state change); 1001 FIFO_WRITE / 1101 LIFO_WRITE (push at tail); 1010 FIFO_READ (pop head); 1110 LIFO_READ (pop tail-1); 1011 FIFO_RW (pop head + push tail same cycle); 1111 LIFO_REPLACE (overwrite top: data_out<=mem[tail-1], mem[tail-1]<=data_in, count unchanged). All other codes: NOP plus err_op.
- Push when full (1001/1101): refused, no state change, err_ovf.
- Pop when empty (1010/1110): refused, out_valid=0, data_out held, err_udf.
- FIFO_RW when full: legal; pop then push, count stays DEPTH, no error. FIFO_RW when empty: push only, count=1, out_valid=0, err_udf.
- LIFO_REPLACE when empty: behaves as push, out_valid=0, err_udf.
- Mode switches need no transition cycle: e.g. FIFO writes A,B,C then LIFO_READ returns C, FIFO_READ returns A.
- Arithmetic: pointer increments/decrements are modulo DEPTH via natural ADDR_W wrap; count is saturating-free since refusals guard it.

## Timing
- Reset values: data_out=0, out_valid=0, empty=1, full=0, count=0, all err_*=0, head=tail=0. Storage contents undefined after reset.
- Read latency 1: command in cycle N, data_out/out_valid valid after edge ending cycle N, for one cycle (out_valid drops next cycle unless another read/BUFFER).
- Write visible to a read in the next cycle (no same-cycle bypass except FIFO_RW/LIFO_REPLACE semantics above; FIFO_RW with count==1 returns the old entry, not data_in).
- empty, full, count are registered and reflect state after the last edge.
- Error flags are registered pulses in the same cycle as out_valid would be.
- reset deasserting mid-stream: first edge after release executes the opcode present; no synchroniser inside the block.

## Structure
- Package squ_pkg: opcode localparams (OP_NOP, OP_CLEAR, OP_BUFFER, OP_FIFO_WRITE, OP_FIFO_READ, OP_FIFO_RW, OP_LIFO_WRITE, OP_LIFO_READ, OP_LIFO_REPLACE) and an op_e enum used by the decoder.
- One sub-module: squ_mem — DEPTH×DATA_W register array, one synchronous write port, one asynchronous read port, no reset on contents.
- Top holds pointers, count, decode and output registers.

## Test plan
- Reset: hold reset=0 two cycles mid-traffic -> empty=1, full=0, count=0, out_valid=0, data_out=0 immediately (async).
- FIFO wrap (DEPTH=4): write 11,22,33,44 -> full=1; write 55 -> err_ovf, count 4; read ×2 -> 11,22; write 66,77; read ×4 -> 33,44,66,77, empty=1.
- LIFO/mixed: write 0A,0B,0C via 1101; 1110 -> 0C; 1010 -> 0A; 1110 -> 0B; 1110 -> err_udf, data_out stays 0B.
- FIFO_RW when full (DEPTH=4, contents 1,2,3,4): 1011 with data_in=5 -> data_out=1, count 4, no error; drain -> 2,3,4,5.
- LIFO_REPLACE: contents 10,20; 1111 with 99 -> data_out=20; 1110 -> 99; 1111 on empty with 42 -> err_udf, count 1.
- BUFFER/illegal/CLEAR: 0100 with 5A -> data_out=5A, out_valid=1, count unchanged; opcode 0110 -> err_op only; 0001 with count 3 -> count 0, empty=1.
